// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  localparam int unsigned       PC_INCR          = 4;
  localparam logic [31:0]       DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and instruction memory (slave).
// Handshake: fetch_req stays high with a stable fetch_addr until the slave
// raises fetch_ack for one cycle with fetch_data valid; the word is taken on that edge.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             fetch_req;
    logic [WIDTH-1:0] fetch_addr;
    logic             fetch_ack;
    logic [WIDTH-1:0] fetch_data;

    modport master (output fetch_req, output fetch_addr, input fetch_ack, input fetch_data);
    modport slave  (input fetch_req, input fetch_addr, output fetch_ack, output fetch_data);
endinterface

// File: rtl/pc_sequencer_target_sel.sv
// Combinational next-PC selection: jr > jump > branch > sequential.
import pc_seq_pkg::*;

module pc_target_sel #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc
);
    logic [WIDTH-1:0] jr_target;

    assign pc_plus4  = pc + WIDTH'(PC_INCR);
    // Low bits are dropped so a misaligned register target still lands on a word.
    assign jr_target = jr_addr & ~{{(WIDTH-2){1'b0}}, 2'b11};

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT -> FETCH -> EXEC loop, next-PC chosen on commit.
// Optional PC_ALIGN_CHECK_EN: misaligned committed jr sets sticky addr_error and halts.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        fetch_if,
    output logic [WIDTH-1:0]      instr,
    output logic                  instr_valid,
    input  logic                  commit,
    input  logic                  branch_taken,
    input  logic [WIDTH-1:0]      branch_offset,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jr,
    input  logic [WIDTH-1:0]      jr_addr,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_plus4,
    output logic                  addr_error,
    output pc_state_t             dbg_state
);
    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             fetch_req_q, fetch_req_d;
    logic             instr_valid_q, instr_valid_d;
    logic             addr_error_q, addr_error_d;
    logic [WIDTH-1:0] next_pc;

    pc_target_sel #(.WIDTH(WIDTH)) u_target_sel (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        addr_error_d = addr_error_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (fetch_if.fetch_ack) begin
                    instr_d = fetch_if.fetch_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (jr && (jr_addr[1:0] != 2'b00)) begin
                        addr_error_d = 1'b1;
                        state_d      = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = FETCH;
`endif
                end
            end
            default: state_d = HALT;
        endcase
        // Outputs are registered from the next state so they align with dbg_state.
        fetch_req_d   = (state_d == FETCH);
        instr_valid_d = (state_d == EXEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= WIDTH'(RESET_PC);
            instr_q       <= '0;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            addr_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_req_q   <= fetch_req_d;
            instr_valid_q <= instr_valid_d;
            addr_error_q  <= addr_error_d;
        end
    end

    assign fetch_if.fetch_req  = fetch_req_q;
    assign fetch_if.fetch_addr = pc_q;
    assign instr               = instr_q;
    assign instr_valid         = instr_valid_q;
    assign pc                  = pc_q;
    assign dbg_state           = state_q;
`ifdef PC_ALIGN_CHECK_EN
    assign addr_error          = addr_error_q;
`else
    assign addr_error          = 1'b0;
`endif
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS core: holds the PC, fetches the instruction at it through a request/acknowledge handshake with instruction memory, and on each committed instruction selects the next PC. Candidates are sequential, branch, jump or register-jump. It consumes the word-aligned branch offset produced by the shift-left-by-2 stage and feeds fetch addresses to instruction memory.

## Interface
- `WIDTH`, 32: PC and data width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  : single clock, rising edge.
- `rst_n`  in  1  : asynchronous, active-low reset.
- `fetch_req`  out  1  : fetch request to instruction memory.
- `fetch_addr`  out  WIDTH  : fetch address; always equals `pc`.
- `fetch_ack`  in  1  : memory returns `fetch_data` this cycle.
- `fetch_data`  in  WIDTH  : instruction word.
- `instr`  out  WIDTH  : registered instruction; valid while `instr_valid`=1.
- `instr_valid`  out  1  : high in EXEC state.
- `commit`  in  1  : control retires the current instruction; next-PC select inputs are valid.
- `branch_taken`  in  1  : take conditional branch.
- `branch_offset`  in  WIDTH  : sign-extended immediate already shifted left by 2.
- `jump`  in  1  : J/JAL.
- `jump_index`  in  26  : instr[25:0].
- `jr`  in  1  : JR/JALR.
- `jr_addr`  in  WIDTH  : register-source target.
- `pc`  out  WIDTH  : current PC.
- `pc_plus4`  out  WIDTH  : `pc` + 4, combinational, used for link writes.
- `addr_error`  out  1  : sticky misaligned-JR flag (see Configuration).

## Operation
- States: BOOT, FETCH, EXEC, HALT.
- BOOT: entered on reset. `fetch_req`=0. Moves to FETCH after one cycle.
- FETCH: `fetch_req`=1. On `fetch_ack`, `instr` is loaded with `fetch_data` and the state moves to EXEC.
- EXEC: `instr_valid`=1. On `commit`, `pc` is loaded with next-PC and the state moves to FETCH. Without `commit`, the state holds indefinitely.
- Next-PC priority is `jr` > `jump` > `branch_taken` > sequential:
  - `jr`: `jr_addr`.
  - `jump`: {`pc_plus4`[WIDTH-1:28], `jump_index`, 2'b00}.
  - `branch_taken`: `pc_plus4` + `branch_offset`.
  - sequential: `pc_plus4`.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent (32'hFFFF_FFFC + 4 = 0).
- `commit` outside EXEC is ignored. `fetch_ack` outside FETCH is ignored. Select inputs are sampled only when `commit`=1.
- HALT: `fetch_req`=0, `instr_valid`=0. Left only by reset.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `fetch_req`=0, `addr_error`=0, state BOOT.
- Reset asserted mid-fetch or mid-EXEC aborts immediately. A pending `fetch_ack` is dropped.
- With a zero-wait memory (`fetch_ack` the same cycle as `fetch_req`), FETCH lasts 1 cycle.
- `pc` changes the cycle after `commit`. Minimum instruction period is 2 cycles (FETCH + EXEC).
- `fetch_addr` is stable for the whole FETCH state.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - a committed `jr` with `jr_addr`[1:0]≠0 does not update `pc`;
  - `addr_error` is set (sticky);
  - the state moves to HALT.
- Undefined:
  - `jr_addr` is used with bits [1:0] forced to 0;
  - `addr_error` is tied 0;
  - HALT is unreachable.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_state_t` (BOOT, FETCH, EXEC, HALT);
  - `PC_INCR`=4;
  - default `RESET_PC`.
- Sub-module `pc_target_sel`: combinational next-PC priority mux and adders. The FSM and registers stay in `pc_sequencer`.

## Test plan
- Reset then `fetch_ack` on the 1st FETCH cycle with `fetch_data`=32'h2008_0005 -> `fetch_addr`=0, `instr`=32'h2008_0005, `instr_valid`=1 the next cycle.
- `pc`=32'h0000_0040, commit with `branch_taken`, `branch_offset`=32'hFFFF_FFF0 -> `pc`=32'h0000_0034.
- `pc`=32'h1000_0000, commit with `jump`, `jump_index`=26'h0000_100 -> `pc`=32'h1000_0400. With `branch_taken` also high, the jump still wins.
- `pc`=32'hFFFF_FFFC, sequential commit -> `pc`=0. `commit` asserted during FETCH -> `pc` unchanged.
- `rst_n` low while waiting in FETCH with `fetch_req`=1 -> all outputs at reset values in the same cycle. The late `fetch_ack` is ignored.
- Macro on: commit `jr`, `jr_addr`=32'h0000_0102 -> `addr_error`=1, HALT, `pc` unchanged. Macro off: same stimulus -> `pc`=32'h0000_0100.
